// File: rtl/fifo_wr_ctrl.sv
module fifo_wr_ctrl #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int WR_IND         = 1,
  parameter int WR_IND_W       = 0,
  parameter int RD_IND         = 4,
  parameter int RD_IND_W       = 2,
  parameter int AF_LEVEL       = 28,
  parameter int WR_PTR_W       = RAM_ADDR_WIDTH + 1 - WR_IND_W,
  parameter int RD_PTR_W       = RAM_ADDR_WIDTH + 1 - RD_IND_W
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst_n,
  input  logic                      wr_req,
  input  logic [RD_PTR_W-1:0]       rd_ptr_gray,
  output logic                      wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [WR_PTR_W-1:0]       wr_ptr_gray,
  output logic                      full,
  output logic                      almost_full,
  output logic [RAM_ADDR_WIDTH:0]   wr_cnt,
  output logic                      wr_overflow
);

  localparam int CNT_W = RAM_ADDR_WIDTH + 1;

  logic [WR_PTR_W-1:0] wr_beat;
  logic [WR_PTR_W-1:0] beat_next;
  logic [RD_PTR_W-1:0] rd_sync1;
  logic [RD_PTR_W-1:0] rd_sync2;
  logic [RD_PTR_W-1:0] rd_bin;
  logic [CNT_W-1:0]    wr_wptr_next;
  logic [CNT_W-1:0]    rd_wptr;
  logic [CNT_W-1:0]    used;
  logic [CNT_W-1:0]    free_words;

  // Truncate before shifting: the address is the word pointer modulo RAM_DEPTH.
  assign wr_addr = RAM_ADDR_WIDTH'(wr_beat) << WR_IND_W;

  // Reset gates the strobe so no write escapes while the pointer is held at 0.
  assign wr_en = wr_req & ~full & wr_rst_n;

  assign beat_next    = wr_beat + WR_PTR_W'(wr_en);
  assign wr_wptr_next = CNT_W'(beat_next) << WR_IND_W;

  always_comb begin
    rd_bin = '0;
    for (int unsigned i = 0; i < RD_PTR_W; i++) begin
      rd_bin[i] = ^(rd_sync2 >> i);
    end
  end

  assign rd_wptr    = CNT_W'(rd_bin) << RD_IND_W;
  assign used       = wr_wptr_next - rd_wptr;
  assign free_words = CNT_W'(RAM_DEPTH) - used;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_beat     <= '0;
      wr_ptr_gray <= '0;
    end else begin
      wr_beat     <= beat_next;
      wr_ptr_gray <= beat_next ^ (beat_next >> 1);
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rd_sync1 <= '0;
      rd_sync2 <= '0;
    end else begin
      rd_sync1 <= rd_ptr_gray;
      rd_sync2 <= rd_sync1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_cnt      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wr_cnt      <= used;
      full        <= free_words < CNT_W'(WR_IND);
      almost_full <= used >= CNT_W'(AF_LEVEL);
      wr_overflow <= wr_req & full;
    end
  end

endmodule
